// File: rtl/sd_image_server.sv
// sd_image_server: responder for the sd_rd/sd_wr/sd_ack/sd_buff_* sector
// protocol. Serves 512-byte sectors out of a byte-wide backing memory that
// holds a disk image, and reports mount events and the image size.
//
// Handshake: sd_rd/sd_wr are request levels sampled only in IDLE. A request
// is accepted when seen in IDLE with an image mounted; sd_ack then rises
// after ACK_DELAY idle cycles and stays high for the whole 512-byte sector.
// Once accepted, the request level is ignored until the sector completes.
// After completion the responder waits in DONE for both requests to drop,
// so a held request never starts a second transfer.
module sd_image_server #(
  parameter int IMG_SECTORS = 320,
  parameter int ADDR_W      = 18,
  parameter int ACK_DELAY   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mount_req,
  input  logic              mount_present,
  output logic              img_mounted,
  output logic [63:0]       img_size,
  input  logic [31:0]       lba,
  input  logic              sd_rd,
  input  logic              sd_wr,
  output logic              sd_ack,
  output logic [8:0]        sd_buff_addr,
  output logic              sd_buff_wr,
  output logic [7:0]        sd_buff_dout,
  input  logic [7:0]        sd_buff_din,
  output logic              lba_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  output logic [2:0]        state_dbg
);

  localparam logic [63:0] IMG_BYTES = 64'(IMG_SECTORS) * 64'd512;
  localparam logic [15:0] DLY_LAST  = (ACK_DELAY > 0) ? 16'(ACK_DELAY - 1) : 16'd0;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DELAY   = 3'd1,
    S_RD_XFER = 3'd2,
    S_WR_XFER = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            state;
  logic              is_wr;     // latched direction
  logic              oor;       // latched lba was outside the image
  logic              rd_pass;   // sd_buff_dout carries mem_rdata this cycle
  logic [ADDR_W-1:0] base;      // latched lba*512
  logic [9:0]        idx;       // cycle index within the transfer, 0..512
  logic [9:0]        idx_n;
  logic [15:0]       dly_cnt;

  logic              accept;
  logic              start;
  logic              req_oor;
  logic [ADDR_W-1:0] req_base;
  logic              go_wr;
  logic              go_oor;
  logic [ADDR_W-1:0] go_base;

  assign state_dbg = state;
  assign idx_n     = idx + 10'd1;
  assign req_oor   = (lba >= 32'(IMG_SECTORS));
  assign req_base  = ADDR_W'({lba, 9'd0});
  assign accept    = (state == S_IDLE) && (sd_rd || sd_wr) && (img_size != 64'd0);
  assign start     = (accept && (ACK_DELAY == 0)) ||
                     ((state == S_DELAY) && (dly_cnt == DLY_LAST));

  // Read data and write data are pass-throughs gated by registered strobes,
  // so they are zero whenever no byte is moving.
  assign sd_buff_dout = rd_pass ? mem_rdata : 8'h00;
  assign mem_wdata    = mem_wr ? sd_buff_din : 8'h00;

  // Transfer parameters used at sd_ack rise: live inputs when starting
  // straight from IDLE (zero delay), otherwise the latched copies.
  always_comb begin
    go_wr   = is_wr;
    go_oor  = oor;
    go_base = base;
    if (state == S_IDLE) begin
      go_wr   = sd_wr;
      go_oor  = req_oor;
      go_base = req_base;
    end
  end

  // Transfer FSM with registered sector-side and memory-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      is_wr        <= 1'b0;
      oor          <= 1'b0;
      rd_pass      <= 1'b0;
      base         <= '0;
      idx          <= '0;
      dly_cnt      <= '0;
      sd_ack       <= 1'b0;
      sd_buff_addr <= '0;
      sd_buff_wr   <= 1'b0;
      mem_addr     <= '0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            is_wr   <= sd_wr;
            oor     <= req_oor;
            base    <= req_base;
            dly_cnt <= '0;
            state   <= S_DELAY;
          end
        end
        S_DELAY: begin
          dly_cnt <= dly_cnt + 16'd1;
        end
        S_RD_XFER: begin
          if (idx == 10'd512) begin
            state        <= S_DONE;
            sd_ack       <= 1'b0;
            sd_buff_wr   <= 1'b0;
            sd_buff_addr <= '0;
            rd_pass      <= 1'b0;
            mem_rd       <= 1'b0;
          end else begin
            // Issue the read for byte idx+1 while presenting byte idx.
            idx          <= idx_n;
            mem_rd       <= !idx_n[9] && !oor;
            mem_addr     <= base + ADDR_W'(idx_n[8:0]);
            sd_buff_wr   <= 1'b1;
            sd_buff_addr <= idx[8:0];
            rd_pass      <= !oor;
          end
        end
        S_WR_XFER: begin
          if (idx == 10'd512) begin
            state        <= S_DONE;
            sd_ack       <= 1'b0;
            sd_buff_addr <= '0;
            mem_wr       <= 1'b0;
          end else begin
            // Present address idx+1 while storing the byte for address idx.
            idx          <= idx_n;
            sd_buff_addr <= idx_n[9] ? 9'd511 : idx_n[8:0];
            mem_wr       <= !oor;
            mem_addr     <= base + ADDR_W'(idx[8:0]);
          end
        end
        S_DONE: begin
          if (!sd_rd && !sd_wr) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // sd_ack rise overrides the IDLE/DELAY arms above.
      if (start) begin
        state        <= go_wr ? S_WR_XFER : S_RD_XFER;
        sd_ack       <= 1'b1;
        idx          <= '0;
        sd_buff_addr <= '0;
        mem_rd       <= !go_wr && !go_oor;
        mem_addr     <= go_base;
      end
    end
  end

  // Mount reporting, independent of the transfer FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      img_mounted <= 1'b0;
      img_size    <= '0;
    end else begin
      img_mounted <= mount_req;
      if (mount_req) img_size <= mount_present ? IMG_BYTES : 64'd0;
    end
  end

  // Sticky request error: bad lba or both directions at once; mount clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      lba_err <= 1'b0;
    end else if (mount_req) begin
      lba_err <= 1'b0;
    end else if (accept && ((sd_rd && sd_wr) || req_oor)) begin
      lba_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sd_image_server.sv
// Bench for sd_image_server: backing memory and client RAM models, a
// spec-level expected image (exp_mem), and per-scenario test tasks.
module tb_sd_image_server;

  localparam int IMG_SECTORS = 320;
  localparam int ADDR_W      = 18;
  localparam int ACK_DELAY   = 4;
  localparam int MEM_BYTES   = 1 << ADDR_W;
  localparam logic [63:0] IMG_BYTES = 64'd163840;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              mount_req, mount_present, img_mounted;
  logic [63:0]       img_size;
  logic [31:0]       lba;
  logic              sd_rd, sd_wr, sd_ack, sd_buff_wr, lba_err;
  logic [8:0]        sd_buff_addr;
  logic [7:0]        sd_buff_dout, sd_buff_din, mem_rdata, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd, mem_wr;
  logic [2:0]        state_dbg;

  sd_image_server #(
    .IMG_SECTORS(IMG_SECTORS), .ADDR_W(ADDR_W), .ACK_DELAY(ACK_DELAY)
  ) dut (
    .clk(clk), .reset(reset),
    .mount_req(mount_req), .mount_present(mount_present),
    .img_mounted(img_mounted), .img_size(img_size),
    .lba(lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_wr(sd_buff_wr),
    .sd_buff_dout(sd_buff_dout), .sd_buff_din(sd_buff_din),
    .lba_err(lba_err), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .state_dbg(state_dbg)
  );

  // ---------------- memory and client models ----------------
  logic [7:0] mem     [0:MEM_BYTES-1];
  logic [7:0] exp_mem [0:MEM_BYTES-1];
  logic [7:0] cram    [0:511];

  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr];
    sd_buff_din <= cram[sd_buff_addr];
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [8:0] obs_addr_q[$];
  logic [7:0] obs_data_q[$];
  int rd_total = 0, wr_total = 0, both_total = 0;
  int tests_run = 0, tests_failed = 0;
  logic exp_err;

  always @(negedge clk) begin
    if (sd_buff_wr) begin
      obs_addr_q.push_back(sd_buff_addr);
      obs_data_q.push_back(sd_buff_dout);
    end
    if (mem_rd) rd_total++;
    if (mem_wr) wr_total++;
    if (mem_rd && mem_wr) both_total++;
  end

  function automatic int mem_diff(output int first);
    int n;
    n = 0;
    first = -1;
    for (int a = 0; a < MEM_BYTES; a++) begin
      if (mem[a] !== exp_mem[a]) begin
        if (first < 0) first = a;
        n++;
      end
    end
    return n;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_mount(input bit present, input string tag);
    @(posedge clk); #1;
    mount_req = 1'b1; mount_present = present;
    @(posedge clk); #1;
    mount_req = 1'b0; mount_present = 1'($urandom_range(0, 1));
    exp_err = 1'b0;
    tests_run++;
    if (img_mounted !== 1'b1) begin
      tests_failed++; $display("FAIL %s img_mounted pulse: got %b want 1", tag, img_mounted);
    end
    tests_run++;
    if (img_size !== (present ? IMG_BYTES : 64'd0)) begin
      tests_failed++; $display("FAIL %s img_size: got %0d want %0d", tag, img_size, present ? IMG_BYTES : 64'd0);
    end
    tests_run++;
    if (lba_err !== 1'b0) begin
      tests_failed++; $display("FAIL %s lba_err cleared: got %b want 0", tag, lba_err);
    end
    @(posedge clk); #1;
    tests_run++;
    if (img_mounted !== 1'b0) begin
      tests_failed++; $display("FAIL %s img_mounted width: got %b want 0", tag, img_mounted);
    end
  endtask

  task automatic do_xfer(input bit do_rd, input bit do_wr, input logic [31:0] l,
                         input bit rand_data, input string tag);
    bit in_range, is_write, ack_prev;
    int base, obs0, rd0, wr0, both0, ack_cyc, done_cyc, drop_at, errs, first, nobs;
    in_range = (l < 32'(IMG_SECTORS));
    is_write = do_wr;
    base = in_range ? int'(l) * 512 : 0;
    exp_q.delete();
    if (is_write) begin
      for (int i = 0; i < 512; i++) cram[i] = rand_data ? 8'($urandom) : ~8'(i);
    end else begin
      for (int i = 0; i < 512; i++) exp_q.push_back(in_range ? exp_mem[base + i] : 8'h00);
    end
    if (!in_range || (do_rd && do_wr)) exp_err = 1'b1;
    obs0 = obs_addr_q.size(); rd0 = rd_total; wr0 = wr_total; both0 = both_total;
    drop_at = $urandom_range(ACK_DELAY + 1, 700);
    @(posedge clk); #1;
    lba = l; sd_rd = do_rd; sd_wr = do_wr;
    ack_cyc = -1; done_cyc = -1; ack_prev = 1'b0;
    for (int cyc = 1; cyc <= 1000 && done_cyc < 0; cyc++) begin
      @(posedge clk); #1;
      if (sd_ack && !ack_prev) ack_cyc = cyc;
      if (!sd_ack && ack_prev) done_cyc = cyc;
      if (ack_cyc >= 0) lba = $urandom;
      if (cyc >= drop_at) begin sd_rd = 1'b0; sd_wr = 1'b0; end
      ack_prev = sd_ack;
    end
    sd_rd = 1'b0; sd_wr = 1'b0;
    tests_run++;
    if (done_cyc < 0) begin
      tests_failed++; $display("FAIL %s timeout: sd_ack did not complete within 1000 cycles (ack_cyc %0d)", tag, ack_cyc);
    end
    tests_run++;
    if (ack_cyc !== 1 + ACK_DELAY) begin
      tests_failed++; $display("FAIL %s ack latency: got %0d want %0d", tag, ack_cyc, 1 + ACK_DELAY);
    end
    tests_run++;
    if (done_cyc !== 2 + ACK_DELAY + 512) begin
      tests_failed++; $display("FAIL %s done latency: got %0d want %0d", tag, done_cyc, 2 + ACK_DELAY + 512);
    end
    nobs = obs_addr_q.size() - obs0;
    tests_run++;
    if (nobs !== (is_write ? 0 : 512)) begin
      tests_failed++; $display("FAIL %s sd_buff_wr pulses: got %0d want %0d", tag, nobs, is_write ? 0 : 512);
    end
    if (!is_write) begin
      errs = 0; first = -1;
      for (int i = obs0; i < obs_addr_q.size(); i++) begin
        logic [7:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        if (obs_addr_q[i] !== 9'(i - obs0) || obs_data_q[i] !== e) begin
          if (first < 0) first = i - obs0;
          errs++;
        end
      end
      tests_run++;
      if (errs != 0) begin
        tests_failed++; $display("FAIL %s rd_data: got %0d bad bytes (first at pulse %0d) want 0", tag, errs, first);
      end
    end
    tests_run++;
    if (rd_total - rd0 !== ((!is_write && in_range) ? 512 : 0)) begin
      tests_failed++; $display("FAIL %s mem_rd count: got %0d want %0d", tag, rd_total - rd0, (!is_write && in_range) ? 512 : 0);
    end
    tests_run++;
    if (wr_total - wr0 !== ((is_write && in_range) ? 512 : 0)) begin
      tests_failed++; $display("FAIL %s mem_wr count: got %0d want %0d", tag, wr_total - wr0, (is_write && in_range) ? 512 : 0);
    end
    tests_run++;
    if (both_total - both0 !== 0) begin
      tests_failed++; $display("FAIL %s mem_rd&mem_wr overlap: got %0d want 0", tag, both_total - both0);
    end
    if (is_write) begin
      if (in_range) for (int i = 0; i < 512; i++) exp_mem[base + i] = cram[i];
      errs = mem_diff(first);
      tests_run++;
      if (errs != 0) begin
        tests_failed++; $display("FAIL %s mem image: got %0d bad bytes (first at %0d) want 0", tag, errs, first);
      end
    end
    tests_run++;
    if ({sd_ack, sd_buff_wr, sd_buff_addr} !== 11'd0) begin
      tests_failed++; $display("FAIL %s done outputs: got ack %b wr %b addr %0d want 0 0 0", tag, sd_ack, sd_buff_wr, sd_buff_addr);
    end
    tests_run++;
    if (lba_err !== exp_err) begin
      tests_failed++; $display("FAIL %s lba_err: got %b want %b", tag, lba_err, exp_err);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    tests_run++;
    if ({img_mounted, img_size, lba_err} !== 66'd0) begin
      tests_failed++; $display("FAIL reset mount outputs: got %b %0d %b want 0 0 0", img_mounted, img_size, lba_err);
    end
    tests_run++;
    if ({sd_ack, sd_buff_wr, sd_buff_addr, sd_buff_dout} !== 19'd0) begin
      tests_failed++; $display("FAIL reset sector outputs: got ack %b wr %b addr %0d dout %h want 0", sd_ack, sd_buff_wr, sd_buff_addr, sd_buff_dout);
    end
    tests_run++;
    if ({mem_rd, mem_wr, mem_wdata, mem_addr} !== 28'd0) begin
      tests_failed++; $display("FAIL reset mem outputs: got rd %b wr %b wdata %h addr %h want 0", mem_rd, mem_wr, mem_wdata, mem_addr);
    end
  endtask

  task automatic test_request_ignored(input string tag);
    int ack_seen, obs0;
    obs0 = obs_addr_q.size();
    ack_seen = 0;
    @(posedge clk); #1;
    lba = 32'($urandom_range(0, 319)); sd_rd = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (sd_ack) ack_seen++;
    end
    sd_rd = 1'b0;
    tests_run++;
    if (ack_seen != 0 || obs_addr_q.size() != obs0) begin
      tests_failed++; $display("FAIL %s: got %0d ack cycles and %0d pulses want 0 0", tag, ack_seen, obs_addr_q.size() - obs0);
    end
  endtask

  task automatic test_random_xfers;
    logic [31:0] l;
    repeat (8) begin
      case ($urandom_range(0, 3))
        0: l = 32'd0;
        1: l = 32'd319;
        default: l = 32'($urandom_range(0, 319));
      endcase
      if ($urandom_range(0, 1) == 1) do_xfer(1'b0, 1'b1, l, 1'b1, "rand_wr");
      else do_xfer(1'b1, 1'b0, l, 1'b1, "rand_rd");
    end
  endtask

  task automatic test_out_of_range;
    do_xfer(1'b1, 1'b0, 32'd400, 1'b1, "oor_rd_400");
    do_xfer(1'b0, 1'b1, 32'd400, 1'b1, "oor_wr_400");
    do_xfer(1'b1, 1'b0, 32'd320, 1'b1, "oor_rd_320");
    do_xfer(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, "oor_wr_max");
    do_mount(1'b1, "mount_clears_err");
  endtask

  task automatic test_both_requests;
    do_xfer(1'b1, 1'b1, 32'd9, 1'b1, "rd_wr_both");
    do_xfer(1'b1, 1'b0, 32'd9, 1'b1, "rd_wr_both_readback");
    do_mount(1'b1, "mount_after_both");
  endtask

  task automatic test_held_request;
    int acks, obs0;
    bit prev;
    obs0 = obs_addr_q.size();
    acks = 0; prev = 1'b0;
    @(posedge clk); #1;
    lba = 32'd7; sd_rd = 1'b1;
    repeat (2000) begin
      @(posedge clk); #1;
      if (sd_ack && !prev) acks++;
      prev = sd_ack;
    end
    tests_run++;
    if (acks != 1) begin
      tests_failed++; $display("FAIL held_request transfers: got %0d want 1", acks);
    end
    tests_run++;
    if (obs_addr_q.size() - obs0 != 512) begin
      tests_failed++; $display("FAIL held_request pulses: got %0d want 512", obs_addr_q.size() - obs0);
    end
    sd_rd = 1'b0;
    repeat (4) @(posedge clk);
    do_xfer(1'b1, 1'b0, 32'd7, 1'b1, "held_retrigger");
  endtask

  task automatic test_reset_mid_write;
    bit found;
    int errs, first;
    logic [112:0] outs;
    for (int i = 0; i < 512; i++) cram[i] = 8'($urandom);
    @(posedge clk); #1;
    lba = 32'd2; sd_wr = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 700 && !found; c++) begin
      @(posedge clk); #1;
      if (sd_ack && sd_buff_addr == 9'd100) found = 1'b1;
    end
    tests_run++;
    if (!found) begin
      tests_failed++; $display("FAIL reset_mid_write reach byte 100: got 0 want 1");
    end
    reset = 1'b1;
    @(posedge clk); #1;
    sd_wr = 1'b0;
    outs = {img_mounted, img_size, sd_ack, sd_buff_addr, sd_buff_wr, sd_buff_dout,
            lba_err, mem_addr, mem_rd, mem_wr, mem_wdata};
    tests_run++;
    if (outs !== '0) begin
      tests_failed++; $display("FAIL reset_mid_write outputs: got %h want 0", outs);
    end
    reset = 1'b0;
    for (int i = 0; i < 100; i++) exp_mem[1024 + i] = cram[i];
    errs = mem_diff(first);
    tests_run++;
    if (errs != 0) begin
      tests_failed++; $display("FAIL reset_mid_write mem image: got %0d bad bytes (first at %0d) want 0", errs, first);
    end
    exp_err = 1'b0;
    do_mount(1'b1, "remount_after_reset");
    do_xfer(1'b1, 1'b0, 32'd2, 1'b1, "read_after_reset");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; mount_req = 1'b0; mount_present = 1'b0;
    lba = '0; sd_rd = 1'b0; sd_wr = 1'b0; exp_err = 1'b0;
    for (int a = 0; a < MEM_BYTES; a++) begin
      mem[a]     = 8'(a) ^ 8'h5A;
      exp_mem[a] = 8'(a) ^ 8'h5A;
    end
    for (int i = 0; i < 512; i++) cram[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    test_reset;
    test_request_ignored("unmounted_ignored");
    do_mount(1'b1, "mount");
    do_xfer(1'b1, 1'b0, 32'd3, 1'b0, "rd_lba3");
    do_xfer(1'b0, 1'b1, 32'd5, 1'b0, "wr_lba5");
    do_xfer(1'b1, 1'b0, 32'd5, 1'b0, "rd_lba5_back");
    test_random_xfers;
    test_out_of_range;
    test_both_requests;
    test_held_request;
    test_reset_mid_write;
    do_mount(1'b0, "eject");
    test_request_ignored("ejected_ignored");
    do_mount(1'b1, "remount");
    do_xfer(1'b1, 1'b0, 32'd5, 1'b1, "rd_after_remount");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
